// File: rtl/serial_tx_scheduler.sv
// serial_tx_scheduler: shares one 7-bit serial transmitter between NREQ requesters.
// Round-robin arbitration at message granularity: an owner keeps the transmitter until
// its last char has gone out, or until it stalls mid-message past STALL_CYCLES.
module serial_tx_scheduler #(
    parameter int unsigned NREQ         = 2,
    parameter int unsigned PTR_W        = 1,
    parameter logic [15:0] STALL_CYCLES = 16'd50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [7*NREQ-1:0] req_char,
    input  logic [NREQ-1:0]   req_last,
    output logic [NREQ-1:0]   req_ready,
    output logic [NREQ-1:0]   grant,
    output logic [6:0]        ser_char,
    output logic              ser_send,
    input  logic              ser_busy,
    output logic              stall_abort
);

    typedef enum logic [1:0] {
        StArb,
        StIssue,
        StWaitBusy,
        StWaitIdle
    } state_e;

    state_e            state_q, state_d;
    logic [PTR_W-1:0]  owner_q, owner_d;
    logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic              last_q, last_d;
    logic [15:0]       stall_cnt_q, stall_cnt_d;
    logic [NREQ-1:0]   grant_q, grant_d;
    logic [NREQ-1:0]   req_ready_q, req_ready_d;
    logic [6:0]        ser_char_q, ser_char_d;
    logic              ser_send_q, ser_send_d;
    logic              stall_abort_q, stall_abort_d;

    logic [6:0]        chars [NREQ];

    // Owner index + 1, wrapping at NREQ (not at 2**PTR_W).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(NREQ - 1)) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    // First valid requester found searching from start upwards, modulo NREQ.
    function automatic logic [PTR_W-1:0] rr_pick(input logic [NREQ-1:0]  v,
                                                 input logic [PTR_W-1:0] start);
        logic [PTR_W-1:0] cand;
        logic [PTR_W-1:0] pick;
        logic             found;
        cand  = start;
        pick  = start;
        found = 1'b0;
        for (int j = 0; j < int'(NREQ); j++) begin
            if (!found && v[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
            cand = ptr_inc(cand);
        end
        return pick;
    endfunction

    function automatic logic [NREQ-1:0] onehot(input logic [PTR_W-1:0] p);
        logic [NREQ-1:0] r;
        r    = '0;
        r[p] = 1'b1;
        return r;
    endfunction

    // Unpack the flat char bus into one entry per requester.
    always_comb begin
        for (int i = 0; i < int'(NREQ); i++) begin
            chars[i] = req_char[7*i +: 7];
        end
    end

    // Next-state and next-output logic of the arbitration/sequencing FSM.
    always_comb begin
        state_d       = state_q;
        owner_d       = owner_q;
        rr_ptr_d      = rr_ptr_q;
        last_d        = last_q;
        stall_cnt_d   = stall_cnt_q;
        grant_d       = grant_q;
        ser_char_d    = ser_char_q;
        req_ready_d   = '0;
        ser_send_d    = 1'b0;
        stall_abort_d = 1'b0;

        unique case (state_q)
            StArb: begin
                stall_cnt_d = '0;
                if (|req_valid) begin
                    owner_d = rr_pick(req_valid, rr_ptr_q);
                    grant_d = onehot(owner_d);
                    state_d = StIssue;
                end else begin
                    grant_d = '0;
                end
            end
            StIssue: begin
                if (req_valid[owner_q]) begin
                    // A valid owner waiting on a busy transmitter is not stalling.
                    if (!ser_busy) begin
                        ser_char_d  = chars[owner_q];
                        ser_send_d  = 1'b1;
                        req_ready_d = onehot(owner_q);
                        last_d      = req_last[owner_q];
                        stall_cnt_d = '0;
                        state_d     = StWaitBusy;
                    end
                end else if (stall_cnt_q >= STALL_CYCLES - 16'd1) begin
                    stall_abort_d = 1'b1;
                    grant_d       = '0;
                    rr_ptr_d      = ptr_inc(owner_q);
                    stall_cnt_d   = '0;
                    state_d       = StArb;
                end else begin
                    stall_cnt_d = stall_cnt_q + 16'd1;
                end
            end
            StWaitBusy: begin
                if (ser_busy) begin
                    state_d = StWaitIdle;
                end
            end
            StWaitIdle: begin
                if (!ser_busy) begin
                    if (last_q) begin
                        grant_d  = '0;
                        rr_ptr_d = ptr_inc(owner_q);
                        state_d  = StArb;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            default: begin
                state_d = StArb;
            end
        endcase
    end

    // State and registered outputs; reset abandons any message in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StArb;
            owner_q       <= '0;
            rr_ptr_q      <= '0;
            last_q        <= 1'b0;
            stall_cnt_q   <= '0;
            grant_q       <= '0;
            req_ready_q   <= '0;
            ser_char_q    <= '0;
            ser_send_q    <= 1'b0;
            stall_abort_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            owner_q       <= owner_d;
            rr_ptr_q      <= rr_ptr_d;
            last_q        <= last_d;
            stall_cnt_q   <= stall_cnt_d;
            grant_q       <= grant_d;
            req_ready_q   <= req_ready_d;
            ser_char_q    <= ser_char_d;
            ser_send_q    <= ser_send_d;
            stall_abort_q <= stall_abort_d;
        end
    end

    assign grant       = grant_q;
    assign req_ready   = req_ready_q;
    assign ser_char    = ser_char_q;
    assign ser_send    = ser_send_q;
    assign stall_abort = stall_abort_q;

endmodule

// File: tb/tb_serial_tx_scheduler.sv
// Bench for serial_tx_scheduler: behavioural transmitter and requesters, round-robin
// message-order reference model, one task per scenario.
module tb_serial_tx_scheduler;

    localparam int N         = 3;
    localparam int STALL     = 20;
    localparam int MAXC      = 64;
    localparam int FRAME_MAX = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [7*N-1:0]   req_char = '0;
    logic [N-1:0]     req_last = '0;
    logic [N-1:0]     req_ready;
    logic [N-1:0]     grant;
    logic [6:0]       ser_char;
    logic             ser_send;
    logic             ser_busy = 1'b0;
    logic             stall_abort;

    always #5 clk = ~clk;

    serial_tx_scheduler #(
        .NREQ         (N),
        .PTR_W        (2),
        .STALL_CYCLES (16'(STALL))
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_char    (req_char),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .grant       (grant),
        .ser_char    (ser_char),
        .ser_send    (ser_send),
        .ser_busy    (ser_busy),
        .stall_abort (stall_abort)
    );

    // Per-requester message storage: chars queued back to back, last flag per char.
    logic [6:0] msg_ch  [N][MAXC];
    bit         msg_lst [N][MAXC];
    int         len [N];
    int         pos [N];
    bit         hold [N];
    int         tx_cnt;

    logic [6:0]   obs_ch[$];
    logic [N-1:0] obs_rdy[$];
    logic [N-1:0] obs_gnt[$];
    logic [6:0]   exp_ch[$];
    int           exp_own[$];
    int           viol;
    int           abort_cnt;
    int           checks = 0;
    int           errors = 0;

    // Transmitter and requester models, updated on the falling edge.
    initial begin
        forever begin
            @(negedge clk or posedge rst);
            if (rst) begin
                ser_busy = 1'b0;
                tx_cnt   = 0;
                for (int i = 0; i < N; i++) pos[i] = 0;
            end else begin
                if (ser_busy) begin
                    tx_cnt--;
                    if (tx_cnt <= 0) ser_busy = 1'b0;
                end
                if (ser_send) begin
                    ser_busy = 1'b1;
                    tx_cnt   = int'($urandom_range(FRAME_MAX, 2));
                end
                for (int i = 0; i < N; i++) if (req_ready[i]) pos[i]++;
            end
            for (int i = 0; i < N; i++) begin
                if (pos[i] < len[i] && !hold[i]) begin
                    req_valid[i]       = 1'b1;
                    req_char[7*i +: 7] = msg_ch[i][pos[i]];
                    req_last[i]        = msg_lst[i][pos[i]];
                end else begin
                    req_valid[i]       = 1'b0;
                    req_char[7*i +: 7] = 7'h00;
                    req_last[i]        = 1'b0;
                end
            end
        end
    end

    function automatic logic [N-1:0] oh(input int i);
        return N'(1) << i;
    endfunction

    // Append nmsg random messages (1..4 chars each) to requester i.
    function automatic void gen_msgs(input int i, input int nmsg);
        int k = len[i];
        for (int m = 0; m < nmsg; m++) begin
            int l = int'($urandom_range(4, 1));
            for (int c = 0; c < l; c++) begin
                msg_ch[i][k]  = 7'($urandom_range(127, 0));
                msg_lst[i][k] = (c == l - 1);
                k++;
            end
        end
        len[i] = k;
    endfunction

    function automatic void put_char(input int i, input logic [6:0] c, input bit last);
        msg_ch[i][len[i]]  = c;
        msg_lst[i][len[i]] = last;
        len[i]++;
    endfunction

    // Reference order when every requester holds valid from reset until its data runs out:
    // whole messages, next owner is the first one with data at or after previous owner + 1.
    function automatic void model_rr();
        int rr = 0;
        int p [N];
        for (int i = 0; i < N; i++) p[i] = 0;
        forever begin
            int o = -1;
            bit done = 1'b0;
            for (int k = 0; k < N; k++) begin
                if (o < 0 && p[(rr + k) % N] < len[(rr + k) % N]) o = (rr + k) % N;
            end
            if (o < 0) break;
            while (!done && p[o] < len[o]) begin
                exp_ch.push_back(msg_ch[o][p[o]]);
                exp_own.push_back(o);
                done = msg_lst[o][p[o]];
                p[o]++;
            end
            rr = (o + 1) % N;
        end
    endfunction

    // Advance one clock and record what the DUT did on it.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (ser_send) begin
            obs_ch.push_back(ser_char);
            obs_rdy.push_back(req_ready);
            obs_gnt.push_back(grant);
            if (ser_busy) viol++;
        end
        if ((req_ready != '0) != ser_send) viol++;
        if ((req_ready & ~grant) != '0) viol++;
        if ((grant & (grant - N'(1))) != '0) viol++;
        if (stall_abort) begin
            abort_cnt++;
            if (grant != '0) viol++;
        end
    endtask

    task automatic run_sends(input int n, input int budget);
        int c = 0;
        while (obs_ch.size() < n && c < budget) begin
            cycle();
            c++;
        end
        repeat (20) cycle();
    endtask

    task automatic reset_begin();
        rst = 1'b1;
        for (int i = 0; i < N; i++) begin
            len[i]  = 0;
            hold[i] = 1'b0;
        end
        obs_ch.delete();
        obs_rdy.delete();
        obs_gnt.delete();
        exp_ch.delete();
        exp_own.delete();
        viol      = 0;
        abort_cnt = 0;
        repeat (2) @(posedge clk);
    endtask

    task automatic reset_end();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        reset_begin();
        #1;
        checks++; if (grant !== '0) begin errors++; $display("FAIL reset_grant: got %b want 0", grant); end
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b want 0", req_ready); end
        checks++; if (ser_send !== 1'b0) begin errors++; $display("FAIL reset_send: got %b want 0", ser_send); end
        checks++; if (ser_char !== 7'h00) begin errors++; $display("FAIL reset_char: got %h want 0", ser_char); end
        checks++; if (stall_abort !== 1'b0) begin errors++; $display("FAIL reset_abort: got %b want 0", stall_abort); end
        reset_end();
        repeat (10) cycle();
        checks++; if (grant !== '0 || obs_ch.size() != 0) begin
            errors++; $display("FAIL idle_no_grant: grant %b sends %0d, want 0 and 0", grant, obs_ch.size());
        end
    endtask

    task automatic test_hello();
        reset_begin();
        put_char(0, 7'h48, 1'b0);
        put_char(0, 7'h69, 1'b1);
        exp_ch = '{7'h48, 7'h69};
        exp_own = '{0, 0};
        reset_end();
        run_sends(2, 200);
        checks++; if (obs_ch.size() != exp_ch.size()) begin
            errors++; $display("FAIL hello_count: got %0d sends want %0d", obs_ch.size(), exp_ch.size());
        end
        for (int k = 0; k < exp_ch.size() && k < obs_ch.size(); k++) begin
            checks++;
            if (obs_ch[k] !== exp_ch[k] || obs_rdy[k] !== oh(exp_own[k]) || obs_gnt[k] !== oh(exp_own[k])) begin
                errors++; $display("FAIL hello_send%0d: got char %h ready %b grant %b, want char %h owner %0d",
                                   k, obs_ch[k], obs_rdy[k], obs_gnt[k], exp_ch[k], exp_own[k]);
            end
        end
        checks++; if (viol != 0) begin errors++; $display("FAIL hello_protocol: %0d violations want 0", viol); end
        checks++; if (grant !== '0) begin errors++; $display("FAIL hello_release: grant %b want 0", grant); end
    endtask

    task automatic test_round_robin();
        reset_begin();
        gen_msgs(0, 2);
        gen_msgs(1, 2);
        model_rr();
        reset_end();
        run_sends(exp_ch.size(), 3000);
        checks++; if (obs_ch.size() != exp_ch.size()) begin
            errors++; $display("FAIL rr_count: got %0d sends want %0d", obs_ch.size(), exp_ch.size());
        end
        for (int k = 0; k < exp_ch.size() && k < obs_ch.size(); k++) begin
            checks++;
            if (obs_ch[k] !== exp_ch[k] || obs_rdy[k] !== oh(exp_own[k]) || obs_gnt[k] !== oh(exp_own[k])) begin
                errors++; $display("FAIL rr_send%0d: got char %h ready %b grant %b, want char %h owner %0d",
                                   k, obs_ch[k], obs_rdy[k], obs_gnt[k], exp_ch[k], exp_own[k]);
            end
        end
        checks++; if (viol != 0) begin errors++; $display("FAIL rr_protocol: %0d violations want 0", viol); end
    endtask

    task automatic test_no_interleave();
        int c = 0;
        int xs = 0;
        reset_begin();
        for (int k = 0; k < 4; k++) begin
            logic [6:0] ch = 7'($urandom_range(127, 0));
            if (ch == 7'h58) ch = 7'h59;
            put_char(1, ch, k == 3);
            exp_ch.push_back(ch);
            exp_own.push_back(1);
        end
        reset_end();
        while (obs_ch.size() < 1 && c < 100) begin
            cycle();
            c++;
        end
        for (int k = 0; k < 3; k++) begin
            put_char(0, 7'h58, k == 2);
            exp_ch.push_back(7'h58);
            exp_own.push_back(0);
        end
        run_sends(7, 1000);
        checks++; if (obs_ch.size() != exp_ch.size()) begin
            errors++; $display("FAIL nointl_count: got %0d sends want %0d", obs_ch.size(), exp_ch.size());
        end
        for (int k = 0; k < exp_ch.size() && k < obs_ch.size(); k++) begin
            checks++;
            if (obs_ch[k] !== exp_ch[k] || obs_rdy[k] !== oh(exp_own[k]) || obs_gnt[k] !== oh(exp_own[k])) begin
                errors++; $display("FAIL nointl_send%0d: got char %h ready %b grant %b, want char %h owner %0d",
                                   k, obs_ch[k], obs_rdy[k], obs_gnt[k], exp_ch[k], exp_own[k]);
            end
        end
        for (int k = 0; k < obs_ch.size(); k++) if (obs_gnt[k] == oh(1) && obs_ch[k] == 7'h58) xs++;
        checks++; if (xs != 0) begin errors++; $display("FAIL nointl_x_under_req1: got %0d want 0", xs); end
        checks++; if (viol != 0) begin errors++; $display("FAIL nointl_protocol: %0d violations want 0", viol); end
    endtask

    task automatic test_stall();
        int c = 0;
        int hc = 0;
        int held = -1;
        reset_begin();
        gen_msgs(0, 0);
        for (int k = 0; k < 3; k++) put_char(0, 7'($urandom_range(127, 0)), k == 2);
        put_char(1, 7'($urandom_range(127, 0)), 1'b0);
        put_char(1, 7'($urandom_range(127, 0)), 1'b1);
        exp_ch = '{msg_ch[0][0], msg_ch[1][0], msg_ch[1][1], msg_ch[0][1], msg_ch[0][2]};
        exp_own = '{0, 1, 1, 0, 0};
        reset_end();
        while (obs_ch.size() < 5 && c < 1000) begin
            cycle();
            c++;
            if (hold[0]) hc++;
            if (obs_ch.size() == 1 && held < 0) hold[0] = 1'b1;
            if (abort_cnt > 0 && held < 0) begin
                held    = hc;
                hold[0] = 1'b0;
            end
        end
        repeat (20) cycle();
        checks++; if (abort_cnt != 1) begin errors++; $display("FAIL stall_abort_count: got %0d want 1", abort_cnt); end
        checks++; if (held < STALL + 2 || held > STALL + 8) begin
            errors++; $display("FAIL stall_timing: abort after %0d held cycles, want %0d..%0d", held, STALL + 2, STALL + 8);
        end
        checks++; if (obs_ch.size() != exp_ch.size()) begin
            errors++; $display("FAIL stall_count: got %0d sends want %0d", obs_ch.size(), exp_ch.size());
        end
        for (int k = 0; k < exp_ch.size() && k < obs_ch.size(); k++) begin
            checks++;
            if (obs_ch[k] !== exp_ch[k] || obs_rdy[k] !== oh(exp_own[k]) || obs_gnt[k] !== oh(exp_own[k])) begin
                errors++; $display("FAIL stall_send%0d: got char %h ready %b grant %b, want char %h owner %0d",
                                   k, obs_ch[k], obs_rdy[k], obs_gnt[k], exp_ch[k], exp_own[k]);
            end
        end
        checks++; if (viol != 0) begin errors++; $display("FAIL stall_protocol: %0d violations want 0", viol); end
    endtask

    task automatic test_async_reset();
        int c = 0;
        reset_begin();
        put_char(0, 7'h55, 1'b0);
        for (int k = 1; k < 6; k++) put_char(0, 7'($urandom_range(127, 0)), k == 5);
        reset_end();
        while (!(obs_ch.size() >= 1 && ser_busy && !ser_send) && c < 100) begin
            cycle();
            c++;
        end
        checks++; if (grant !== 3'b001 || ser_char !== 7'h55) begin
            errors++; $display("FAIL arst_pre: grant %b char %h, want 001 and 55", grant, ser_char);
        end
        #3;
        rst = 1'b1;
        #1;
        checks++; if (grant !== '0) begin errors++; $display("FAIL arst_grant: got %b want 0", grant); end
        checks++; if (req_ready !== '0 || ser_send !== 1'b0) begin
            errors++; $display("FAIL arst_pulses: ready %b send %b want 0", req_ready, ser_send);
        end
        checks++; if (ser_char !== 7'h00) begin errors++; $display("FAIL arst_char: got %h want 0", ser_char); end
        reset_begin();
        gen_msgs(1, 1);
        gen_msgs(0, 1);
        model_rr();
        reset_end();
        run_sends(exp_ch.size(), 1000);
        checks++; if (obs_ch.size() != exp_ch.size()) begin
            errors++; $display("FAIL arst_count: got %0d sends want %0d", obs_ch.size(), exp_ch.size());
        end
        for (int k = 0; k < exp_ch.size() && k < obs_ch.size(); k++) begin
            checks++;
            if (obs_ch[k] !== exp_ch[k] || obs_rdy[k] !== oh(exp_own[k]) || obs_gnt[k] !== oh(exp_own[k])) begin
                errors++; $display("FAIL arst_send%0d: got char %h ready %b grant %b, want char %h owner %0d",
                                   k, obs_ch[k], obs_rdy[k], obs_gnt[k], exp_ch[k], exp_own[k]);
            end
        end
    endtask

    task automatic test_wrap();
        int c = 0;
        reset_begin();
        put_char(2, 7'($urandom_range(127, 0)), 1'b0);
        put_char(2, 7'($urandom_range(127, 0)), 1'b1);
        reset_end();
        while (obs_ch.size() < 1 && c < 100) begin
            cycle();
            c++;
        end
        put_char(0, 7'($urandom_range(127, 0)), 1'b1);
        put_char(1, 7'($urandom_range(127, 0)), 1'b1);
        exp_ch = '{msg_ch[2][0], msg_ch[2][1], msg_ch[0][0], msg_ch[1][0]};
        exp_own = '{2, 2, 0, 1};
        run_sends(4, 1000);
        checks++; if (obs_ch.size() != exp_ch.size()) begin
            errors++; $display("FAIL wrap_count: got %0d sends want %0d", obs_ch.size(), exp_ch.size());
        end
        for (int k = 0; k < exp_ch.size() && k < obs_ch.size(); k++) begin
            checks++;
            if (obs_ch[k] !== exp_ch[k] || obs_rdy[k] !== oh(exp_own[k]) || obs_gnt[k] !== oh(exp_own[k])) begin
                errors++; $display("FAIL wrap_send%0d: got char %h ready %b grant %b, want char %h owner %0d",
                                   k, obs_ch[k], obs_rdy[k], obs_gnt[k], exp_ch[k], exp_own[k]);
            end
        end
        checks++; if (viol != 0) begin errors++; $display("FAIL wrap_protocol: %0d violations want 0", viol); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            reset_begin();
            for (int i = 0; i < N; i++) gen_msgs(i, int'($urandom_range(3, 0)));
            model_rr();
            reset_end();
            run_sends(exp_ch.size(), 5000);
            checks++; if (obs_ch.size() != exp_ch.size()) begin
                errors++; $display("FAIL rand%0d_count: got %0d sends want %0d", it, obs_ch.size(), exp_ch.size());
            end
            for (int k = 0; k < exp_ch.size() && k < obs_ch.size(); k++) begin
                checks++;
                if (obs_ch[k] !== exp_ch[k] || obs_rdy[k] !== oh(exp_own[k]) || obs_gnt[k] !== oh(exp_own[k])) begin
                    errors++; $display("FAIL rand%0d_send%0d: got char %h ready %b grant %b, want char %h owner %0d",
                                       it, k, obs_ch[k], obs_rdy[k], obs_gnt[k], exp_ch[k], exp_own[k]);
                end
            end
            checks++; if (viol != 0) begin errors++; $display("FAIL rand%0d_protocol: %0d violations want 0", it, viol); end
        end
    endtask

    initial begin
        test_reset();
        test_hello();
        test_round_robin();
        test_no_interleave();
        test_stall();
        test_async_reset();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
